// File: rtl/mnist_nn_pkg.sv
// Shared definitions for the MNIST run sequencer: FSM state encoding and default widths.
package mnist_nn_pkg;

  localparam int DEF_W_ADDR_LEN = 20;
  localparam int DEF_X_ADDR_LEN = 10;
  localparam int DEF_DATA_LEN   = 1;
  localparam int DEF_SEL_LEN    = 2;
  localparam int DEF_CYC_LEN    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_X,
    ST_COMPUTE,
    ST_DONE
  } seq_state_e;

  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mnist_nn_seq_if.sv
// Bundles the load stream, the compute-module memory requests and the shared memory port.
interface mnist_nn_seq_if
  import mnist_nn_pkg::*;
#(
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int SEL_LEN    = DEF_SEL_LEN
) ();

  logic                  s_valid;
  logic [DATA_LEN-1:0]   s_data;
  logic                  s_ready;

  logic                  cm_en;
  logic                  cm_finish;
  logic                  cm_w_wq;
  logic                  cm_x_wq;
  logic [W_ADDR_LEN-1:0] cm_w_addr;
  logic [X_ADDR_LEN-1:0] cm_x_addr;
  logic [SEL_LEN-1:0]    cm_w_sel;
  logic [SEL_LEN-1:0]    cm_x_sel;
  logic [DATA_LEN-1:0]   cm_wx_write;

  logic                  mem_we_w;
  logic                  mem_we_x;
  logic [W_ADDR_LEN-1:0] mem_addr_w;
  logic [X_ADDR_LEN-1:0] mem_addr_x;
  logic [SEL_LEN-1:0]    mem_sel_w;
  logic [SEL_LEN-1:0]    mem_sel_x;
  logic [DATA_LEN-1:0]   mem_data_in;

  // The sequencer is the slave of the stream and compute side, and the owner of the memory port.
  modport slave (
    input  s_valid, s_data, cm_finish,
    input  cm_w_wq, cm_x_wq, cm_w_addr, cm_x_addr, cm_w_sel, cm_x_sel, cm_wx_write,
    output s_ready, cm_en,
    output mem_we_w, mem_we_x, mem_addr_w, mem_addr_x, mem_sel_w, mem_sel_x, mem_data_in
  );

  modport master (
    output s_valid, s_data, cm_finish,
    output cm_w_wq, cm_x_wq, cm_w_addr, cm_x_addr, cm_w_sel, cm_x_sel, cm_wx_write,
    input  s_ready, cm_en,
    input  mem_we_w, mem_we_x, mem_addr_w, mem_addr_x, mem_sel_w, mem_sel_x, mem_data_in
  );

endinterface

// File: rtl/nn_load_ctr.sv
// Load address counter: clears on request, steps once per accepted beat and flags the
// final beat of the currently selected length.
module nn_load_ctr #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] len,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Clear wins over increment so the terminal beat wraps the counter back to zero.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == (len - WIDTH'(1)));

endmodule

// File: rtl/mnist_nn_seq.sv
// Run sequencer: streams W then X bits into memory with internal addressing, then hands the
// memory port to the compute module and measures how long it runs.
module mnist_nn_seq
  import mnist_nn_pkg::*;
#(
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int SEL_LEN    = DEF_SEL_LEN,
  parameter int CYC_LEN    = DEF_CYC_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W_ADDR_LEN-1:0] w_len,
  input  logic [X_ADDR_LEN-1:0] x_len,
  input  logic [SEL_LEN-1:0]    w_sel_cfg,
  input  logic [SEL_LEN-1:0]    x_sel_cfg,
  mnist_nn_seq_if.slave         bus,
  output logic                  busy,
  output logic                  done,
  output logic [CYC_LEN-1:0]    compute_cycles
);

  localparam int CTR_LEN = max_len(W_ADDR_LEN, X_ADDR_LEN);

  seq_state_e            state_reg;
  seq_state_e            state_next;
  logic [W_ADDR_LEN-1:0] w_len_reg;
  logic [X_ADDR_LEN-1:0] x_len_reg;
  logic [SEL_LEN-1:0]    w_sel_reg;
  logic [SEL_LEN-1:0]    x_sel_reg;
  logic [CYC_LEN-1:0]    cyc_reg;

  logic                  start_ok;
  logic                  loading;
  logic                  beat;
  logic [CTR_LEN-1:0]    ctr_len;
  logic [CTR_LEN-1:0]    ctr;
  logic                  ctr_last;
  logic                  ctr_clr;

  assign start_ok = (state_reg == ST_IDLE) && start;
  assign loading  = (state_reg == ST_LOAD_W) || (state_reg == ST_LOAD_X);
  assign beat     = loading && bus.s_valid;
  assign ctr_len  = (state_reg == ST_LOAD_X) ? CTR_LEN'(x_len_reg) : CTR_LEN'(w_len_reg);
  assign ctr_clr  = start_ok || (beat && ctr_last);

  nn_load_ctr #(
    .WIDTH (CTR_LEN)
  ) u_load_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .inc   (beat),
    .len   (ctr_len),
    .count (ctr),
    .last  (ctr_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (w_len != '0) begin
            state_next = ST_LOAD_W;
          end else if (x_len != '0) begin
            state_next = ST_LOAD_X;
          end else begin
            state_next = ST_COMPUTE;
          end
        end
      end
      ST_LOAD_W: begin
        if (beat && ctr_last) begin
          state_next = (x_len_reg != '0) ? ST_LOAD_X : ST_COMPUTE;
        end
      end
      ST_LOAD_X: begin
        if (beat && ctr_last) begin
          state_next = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (bus.cm_finish) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      w_len_reg <= '0;
      x_len_reg <= '0;
      w_sel_reg <= '0;
      x_sel_reg <= '0;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        w_len_reg <= w_len;
        x_len_reg <= x_len;
        w_sel_reg <= w_sel_cfg;
        x_sel_reg <= x_sel_cfg;
        cyc_reg   <= '0;
      end else if ((state_reg == ST_COMPUTE) && (cyc_reg != {CYC_LEN{1'b1}})) begin
        cyc_reg <= cyc_reg + CYC_LEN'(1);
      end
    end
  end

  assign bus.s_ready    = loading;
  assign bus.cm_en      = (state_reg == ST_COMPUTE);
  assign busy           = (state_reg != ST_IDLE);
  assign done           = (state_reg == ST_DONE);
  assign compute_cycles = cyc_reg;

  // Memory port mux: the loader owns it only on an accepted beat; during COMPUTE the compute
  // module's write request, address, select and write data pass straight through.
  always_comb begin
    bus.mem_we_w    = 1'b0;
    bus.mem_we_x    = 1'b0;
    bus.mem_addr_w  = '0;
    bus.mem_addr_x  = '0;
    bus.mem_sel_w   = '0;
    bus.mem_sel_x   = '0;
    bus.mem_data_in = '0;
    case (state_reg)
      ST_LOAD_W: begin
        if (beat) begin
          bus.mem_we_w    = 1'b1;
          bus.mem_addr_w  = ctr[W_ADDR_LEN-1:0];
          bus.mem_sel_w   = w_sel_reg;
          bus.mem_data_in = bus.s_data;
        end
      end
      ST_LOAD_X: begin
        if (beat) begin
          bus.mem_we_x    = 1'b1;
          bus.mem_addr_x  = ctr[X_ADDR_LEN-1:0];
          bus.mem_sel_x   = x_sel_reg;
          bus.mem_data_in = bus.s_data;
        end
      end
      ST_COMPUTE: begin
        bus.mem_we_w    = bus.cm_w_wq;
        bus.mem_we_x    = bus.cm_x_wq;
        bus.mem_addr_w  = bus.cm_w_addr;
        bus.mem_addr_x  = bus.cm_x_addr;
        bus.mem_sel_w   = bus.cm_w_sel;
        bus.mem_sel_x   = bus.cm_x_sel;
        bus.mem_data_in = bus.cm_wx_write;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mnist_nn_seq.sv
// Randomised self-checking bench for mnist_nn_seq against a run-level behavioural model.
module tb_mnist_nn_seq;
  import mnist_nn_pkg::*;

  localparam int WA = DEF_W_ADDR_LEN;
  localparam int XA = DEF_X_ADDR_LEN;
  localparam int SL = DEF_SEL_LEN;
  localparam int CL = DEF_CYC_LEN;
  localparam longint CYC_MAX = (longint'(1) << CL) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WA-1:0] w_len;
  logic [XA-1:0] x_len;
  logic [SL-1:0] w_sel_cfg;
  logic [SL-1:0] x_sel_cfg;
  logic          busy;
  logic          done;
  logic [CL-1:0] compute_cycles;

  mnist_nn_seq_if bus ();

  mnist_nn_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .w_len          (w_len),
    .x_len          (x_len),
    .w_sel_cfg      (w_sel_cfg),
    .x_sel_cfg      (x_sel_cfg),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .compute_cycles (compute_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: phase 0 idle, 1 loading W, 2 loading X, 3 computing, 4 reporting done.
  int     m_phase = 0;
  int     m_beats = 0;
  int     m_wlen = 0, m_xlen = 0, m_wsel = 0, m_xsel = 0;
  longint m_cycles = 0;
  bit     chk_en = 1'b0;

  int act_w[int];
  int act_x[int];
  int act_w_sel[int];
  int act_x_sel[int];

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = 0;
      m_beats  = 0;
      m_cycles = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_wlen = int'(w_len); m_xlen = int'(x_len);
          m_wsel = int'(w_sel_cfg); m_xsel = int'(x_sel_cfg);
          m_cycles = 0; m_beats = 0;
          m_phase = (m_wlen != 0) ? 1 : ((m_xlen != 0) ? 2 : 3);
        end
        1: if (bus.s_valid) begin
          m_beats++;
          if (m_beats == m_wlen) begin
            m_beats = 0;
            m_phase = (m_xlen != 0) ? 2 : 3;
          end
        end
        2: if (bus.s_valid) begin
          m_beats++;
          if (m_beats == m_xlen) begin
            m_beats = 0;
            m_phase = 3;
          end
        end
        3: begin
          if (m_cycles < CYC_MAX) m_cycles++;
          if (bus.cm_finish) m_phase = 4;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [3:0]  e_ctrl, a_ctrl;
    logic [36:0] e_mem, a_mem;
    if (chk_en) begin
      e_ctrl = {(m_phase == 1) || (m_phase == 2), m_phase == 3, m_phase != 0, m_phase == 4};
      a_ctrl = {bus.s_ready, bus.cm_en, busy, done};
      e_mem  = '0;
      if (m_phase == 1 && bus.s_valid)
        e_mem = {1'b1, 1'b0, WA'(m_beats), XA'(0), SL'(m_wsel), SL'(0), bus.s_data};
      else if (m_phase == 2 && bus.s_valid)
        e_mem = {1'b0, 1'b1, WA'(0), XA'(m_beats), SL'(0), SL'(m_xsel), bus.s_data};
      else if (m_phase == 3)
        e_mem = {bus.cm_w_wq, bus.cm_x_wq, bus.cm_w_addr, bus.cm_x_addr,
                 bus.cm_w_sel, bus.cm_x_sel, bus.cm_wx_write};
      a_mem = {bus.mem_we_w, bus.mem_we_x, bus.mem_addr_w, bus.mem_addr_x,
               bus.mem_sel_w, bus.mem_sel_x, bus.mem_data_in};
      check("cyc_ctrl{s_ready,cm_en,busy,done}", longint'(a_ctrl), longint'(e_ctrl));
      check("cyc_mem_port", longint'(a_mem), longint'(e_mem));
      check("cyc_compute_cycles", longint'(compute_cycles), m_cycles);
      if (m_phase == 1 && bus.mem_we_w) begin
        act_w[int'(bus.mem_addr_w)]     = int'(bus.mem_data_in);
        act_w_sel[int'(bus.mem_addr_w)] = int'(bus.mem_sel_w);
      end
      if (m_phase == 2 && bus.mem_we_x) begin
        act_x[int'(bus.mem_addr_x)]     = int'(bus.mem_data_in);
        act_x_sel[int'(bus.mem_addr_x)] = int'(bus.mem_sel_x);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cm();
    bus.cm_w_wq     = 1'($urandom);
    bus.cm_x_wq     = 1'($urandom);
    bus.cm_w_addr   = WA'($urandom);
    bus.cm_x_addr   = XA'($urandom);
    bus.cm_w_sel    = SL'($urandom);
    bus.cm_x_sel    = SL'($urandom);
    bus.cm_wx_write = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      start         = 1'b0;
      bus.s_valid   = noisy ? 1'($urandom) : 1'b0;
      bus.s_data    = 1'($urandom);
      bus.cm_finish = noisy ? 1'($urandom) : 1'b0;
      if (noisy) rand_cm();
      cyc();
    end
  endtask

  // gap: 0 continuous, 1 idle/valid alternating, 2 random valid
  task automatic run(input int wl, input int xl, input int ws, input int xs,
                     input logic [31:0] wbits, input logic [31:0] xbits,
                     input int gap, input int fin, input bit noisy);
    int  total, k, it;
    bit  v;
    logic b;
    act_w.delete(); act_x.delete(); act_w_sel.delete(); act_x_sel.delete();
    w_len = WA'(wl); x_len = XA'(xl); w_sel_cfg = SL'(ws); x_sel_cfg = SL'(xs);
    bus.s_valid = 1'b0; bus.cm_finish = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total = wl + xl;
    if (total == 0) check("zero_len_cm_en_next", longint'(bus.cm_en), 1);
    else            check("start_to_s_ready", longint'(bus.s_ready), 1);
    k = 0;
    it = 0;
    while (k < total) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (it % 2) == 1;
        default: v = 1'($urandom);
      endcase
      b = (k < wl) ? wbits[k] : xbits[k - wl];
      bus.s_valid = v;
      bus.s_data  = v ? b : 1'($urandom);
      if (noisy) begin
        start = 1'($urandom);
        w_len = WA'($urandom);
        x_len = XA'($urandom);
        bus.cm_finish = 1'($urandom);
        rand_cm();
      end
      if (v && k == 0) begin
        #1;
        check("first_beat_we_w", longint'(bus.mem_we_w), (wl != 0) ? 1 : 0);
        check("first_beat_we_x", longint'(bus.mem_we_x), (wl == 0) ? 1 : 0);
      end
      if (v && k == total - 1) begin
        #1;
        check("last_beat_cm_en_low", longint'(bus.cm_en), 0);
      end
      cyc();
      if (v) k++;
      it++;
    end
    start = 1'b0;
    w_len = WA'(wl); x_len = XA'(xl);
    if (total > 0) check("last_beat_to_cm_en", longint'(bus.cm_en), 1);
    for (int i = 1; i <= fin; i++) begin
      bus.cm_finish = (i == fin);
      bus.s_valid   = 1'($urandom);
      start         = noisy ? 1'($urandom) : 1'b0;
      rand_cm();
      cyc();
    end
    bus.cm_finish = 1'b0;
    start = noisy ? 1'($urandom) : 1'b0;
    check("done_pulse", longint'(done), 1);
    check("done_compute_cycles", longint'(compute_cycles), fin);
    check("model_compute_cycles", m_cycles, fin);
    cyc();
    start = 1'b0;
    bus.s_valid = 1'b0;
    check("idle_after_done_busy", longint'(busy), 0);
    check("idle_after_done_done", longint'(done), 0);
    check("cycles_hold_in_idle", longint'(compute_cycles), fin);
    for (int a = 0; a < wl; a++) begin
      check("w_mem_bit", act_w.exists(a) ? act_w[a] : -1, wbits[a]);
      check("w_mem_sel", act_w_sel.exists(a) ? act_w_sel[a] : -1, ws);
    end
    for (int a = 0; a < xl; a++) begin
      check("x_mem_bit", act_x.exists(a) ? act_x[a] : -1, xbits[a]);
      check("x_mem_sel", act_x_sel.exists(a) ? act_x_sel[a] : -1, xs);
    end
    $display("run w_len=%0d x_len=%0d w_sel=%0d x_sel=%0d gap=%0d fin=%0d noisy=%0d cycles=%0d",
             wl, xl, ws, xs, gap, fin, noisy, compute_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; w_len = '0; x_len = '0; w_sel_cfg = '0; x_sel_cfg = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.cm_finish = 1'b0;
    bus.cm_w_wq = 1'b0; bus.cm_x_wq = 1'b0; bus.cm_w_addr = '0; bus.cm_x_addr = '0;
    bus.cm_w_sel = '0; bus.cm_x_sel = '0; bus.cm_wx_write = '0;
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycles(10, 1'b0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_s_ready", longint'(bus.s_ready), 0);
    check("reset_cm_en", longint'(bus.cm_en), 0);
    check("reset_cycles", longint'(compute_cycles), 0);
    check("reset_mem_port", longint'({bus.mem_we_w, bus.mem_we_x, bus.mem_addr_w, bus.mem_addr_x,
                                      bus.mem_sel_w, bus.mem_sel_x, bus.mem_data_in}), 0);
    idle_cycles(4, 1'b1);

    // Full run, gapped run with the same load, zero-length skips
    run(4, 3, 2, 1, 32'b1101, 32'b110, 0, 5, 1'b0);
    idle_cycles(2, 1'b0);
    run(4, 3, 2, 1, 32'b1101, 32'b110, 1, 5, 1'b0);
    idle_cycles(2, 1'b0);
    run(0, 2, 3, 2, 32'b0, 32'b10, 0, 3, 1'b0);
    idle_cycles(2, 1'b0);
    run(0, 0, 1, 1, 32'b0, 32'b0, 0, 1, 1'b0);
    idle_cycles(2, 1'b1);

    // Ignored start / s_valid / cm_finish while busy or idle
    run(3, 2, 1, 3, 32'b101, 32'b01, 0, 4, 1'b1);
    idle_cycles(3, 1'b1);

    // Reset after two W beats, then a clean run must restart at address 0
    w_len = WA'(4); x_len = XA'(2); w_sel_cfg = SL'(1); x_sel_cfg = SL'(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 1'($urandom);
      cyc();
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_reset_busy", longint'(busy), 0);
    check("mid_reset_s_ready", longint'(bus.s_ready), 0);
    run(4, 2, 2, 0, 32'b0110, 32'b11, 0, 2, 1'b0);
    idle_cycles(2, 1'b0);

    for (int r = 0; r < 20; r++) begin
      run($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom, $urandom, 2, $urandom_range(1, 6), 1'b1);
      idle_cycles($urandom_range(1, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mnist_nn_seq.md
# mnist_nn_seq

Top-level run sequencer for the MNIST accelerator. It replaces the raw `load_compute_ctrl` port mux with an FSM that does two things in order:
- streams weight and input bits from off-chip into the W/X memories, generating addresses internally;
- then enables the compute module, waits for `compute_finish`, and reports completion and compute cycle count.

It owns the write/address/select side of both memory ports. Memory read data goes directly from `mem_sys` to the compute module.

## Interface
- W_ADDR_LEN, 20, weight memory address width
- X_ADDR_LEN, 10, input memory address width
- DATA_LEN, 1, memory data width (W and X)
- SEL_LEN, 2, bank-select width
- CYC_LEN, 24, compute cycle counter width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  run request; sampled in IDLE only
- w_len  in  W_ADDR_LEN  weight bits to load; 0 = skip weight load
- x_len  in  X_ADDR_LEN  input bits to load; 0 = skip input load
- w_sel_cfg / x_sel_cfg  in  SEL_LEN  bank select used during load
- s_valid  in  1  load stream beat valid
- s_data  in  DATA_LEN  load stream data
- s_ready  out  1  load stream ready
- cm_en  out  1  compute enable (level)
- cm_finish  in  1  compute done
- cm_w_wq, cm_x_wq, cm_w_addr, cm_x_addr, cm_w_sel, cm_x_sel, cm_wx_write  in  (port widths)  compute-module memory requests
- mem_we_w, mem_we_x  out  1  memory write enables
- mem_addr_w  out  W_ADDR_LEN
- mem_addr_x  out  X_ADDR_LEN
- mem_sel_w, mem_sel_x  out  SEL_LEN
- mem_data_in  out  DATA_LEN
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- compute_cycles  out  CYC_LEN  cycles spent in COMPUTE during the last run

## Operation
States are IDLE, LOAD_W, LOAD_X, COMPUTE, DONE.

- **IDLE.** `start=1` latches `w_len`, `x_len`, `w_sel_cfg` and `x_sel_cfg`. It clears the address counter and `compute_cycles`. Next state is:
  - LOAD_W if `w_len != 0`;
  - else LOAD_X if `x_len != 0`;
  - else COMPUTE.
- **LOAD_W.**
  - `s_ready=1`.
  - Each beat (`s_valid & s_ready`) drives `mem_we_w=1`, `mem_addr_w=ctr`, `mem_data_in=s_data` and `mem_sel_w=w_sel_cfg` combinationally in the same cycle; the memory writes at that edge.
  - `ctr` increments per beat.
  - The beat with `ctr == w_len-1` clears `ctr` and moves to LOAD_X if `x_len != 0`, else COMPUTE.
  - A cycle with no beat causes no write and no counter change.
- **LOAD_X.** Same as LOAD_W, using the `x` ports and `x_len`. The last beat moves to COMPUTE.
- **COMPUTE.**
  - `cm_en=1`. All `mem_*` outputs pass through the `cm_*` inputs combinationally.
  - `s_ready=0`.
  - `compute_cycles` increments every cycle and saturates at all-ones.
  - `cm_finish=1` moves to DONE.
- **DONE.** `done=1`, `cm_en=0`, next state IDLE.

**Outside the load and compute states:** both write enables are 0, and addresses, selects and data are 0.

**Boundary conditions:**
- `start` while `busy` is ignored.
- `s_valid` outside the load states is ignored: no write, no stall.
- `cm_finish` outside COMPUTE is ignored.
- `cm_finish` asserted in the first COMPUTE cycle gives `compute_cycles = 1`.
- `rst` in any state: next cycle is IDLE, the counter clears, and all outputs return to their reset values. Partially loaded memory contents are not touched.

## Timing
- **Reset values:** `s_ready=0`, `cm_en=0`, all `mem_*` = 0, `busy=0`, `done=0`, `compute_cycles=0`.
- **Load path:** zero latency from beat to memory write. Throughput is one bit per cycle.
- **Start to first writable beat:** `start` at cycle t gives `s_ready=1` at t+1.
- **Load to compute:** the last beat at cycle t gives `cm_en=1` at t+1.
- **Finish:** `cm_finish` at cycle t gives `done=1` at t+1 and `busy=0` at t+2.
- **Output visibility:** `compute_cycles` is valid from the `done` cycle and holds until the next accepted `start`.

## Structure
- **Shared package `mnist_nn_pkg`:** state enum, default address/data/select widths, `CYC_LEN`.
- **Sub-module `nn_load_ctr`:** parametrised-width load counter with clear, increment and terminal-count output, instantiated once and reused for both W and X loads.
- **Port mux:** stays in this block.

## Test plan
1. **Reset and idle.** Reset, then hold idle 10 cycles → every output is 0 and `busy=0`.
2. **Full run.** `w_len=4`, `x_len=3`, `w_sel_cfg=2`, `x_sel_cfg=1`; stream 1,0,1,1 then 0,1,1 with continuous `s_valid`; `cm_finish` 5 cycles after `cm_en` rises.
   - Required: writes at W addresses 0-3 with sel 2, then X addresses 0-2 with sel 1.
   - Required: `cm_en` the cycle after the 7th beat, `done` pulse, `compute_cycles=5`.
3. **Gapped stream.** Same load as scenario 2 with `s_valid` toggling every other cycle → identical memory contents; load takes 2× the cycles; no spurious writes.
4. **Zero-length skips.**
   - `w_len=0`, `x_len=2` → goes directly to LOAD_X.
   - Both lengths 0 → `cm_en` at t+1 after `start`.
5. **Ignored inputs.** `start` pulse during COMPUTE, and `s_valid` during COMPUTE and IDLE → no state change, `mem_*` follows only `cm_*`.
6. **Reset mid-run.** Assert `rst` mid-LOAD_W after 2 beats → IDLE next cycle; the following run writes starting at address 0.
